// File: rtl/mcac_delay_line.sv
// Multi-channel tapped delay line for the MCAC predictor: DEPTH past samples per
// channel, time-multiplexed over NCH channels, with per-channel clear and fill status.

module mcac_delay_line_chan #(
    parameter int               WIDTH = 11,
    parameter int               DEPTH = 6,
    parameter logic [WIDTH-1:0] RV    = '0
) (
    input  logic                        clk,
    input  logic                        R,
    input  logic                        en,
    input  logic                        clr,
    input  logic [WIDTH-1:0]            x,
    output logic [DEPTH-1:0][WIDTH-1:0] taps,
    output logic                        primed
);
    localparam int FW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] tap;
    logic [FW-1:0]               fill;

    always_ff @(posedge clk) begin
        if (!R) begin
            tap  <= {DEPTH{RV}};
            fill <= '0;
        end else if (clr) begin
            // A sample arriving with the clear is kept as the first tap.
            tap <= {DEPTH{RV}};
            if (en) begin
                tap[0] <= x;
                fill   <= FW'(1);
            end else begin
                fill <= '0;
            end
        end else if (en) begin
            tap[0] <= x;
            for (int k = 1; k < DEPTH; k++) tap[k] <= tap[k-1];
            if (fill != FW'(DEPTH)) fill <= fill + FW'(1);
        end
    end

    assign taps   = tap;
    assign primed = (fill == FW'(DEPTH));
endmodule

module mcac_delay_line #(
    parameter int          WIDTH       = 11,
    parameter int          DEPTH       = 6,
    parameter int          NCH         = 4,
    parameter int unsigned RESET_VALUE = 32,
    localparam int         CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic                   en,
    input  logic                   clr,
    input  logic [CW-1:0]          ch,
    input  logic [WIDTH-1:0]       x,
    output logic [DEPTH*WIDTH-1:0] taps,
    output logic [WIDTH-1:0]       y,
    output logic                   primed
);
    localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VALUE);

    logic [NCH-1:0][DEPTH-1:0][WIDTH-1:0] ch_taps;
    logic [NCH-1:0]                       ch_primed;
    logic [NCH-1:0]                       sel;

    // Out-of-range ch matches no channel, so writes drop and reads fall to defaults.
    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            assign sel[c] = (ch == CW'(c));
            mcac_delay_line_chan #(
                .WIDTH(WIDTH),
                .DEPTH(DEPTH),
                .RV   (RV)
            ) u_chan (
                .clk   (clk),
                .R     (R),
                .en    (en & sel[c]),
                .clr   (clr & sel[c]),
                .x     (x),
                .taps  (ch_taps[c]),
                .primed(ch_primed[c])
            );
        end
    endgenerate

    always_comb begin
        taps   = {DEPTH{RV}};
        primed = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel[i]) begin
                taps   = ch_taps[i];
                primed = ch_primed[i];
            end
        end
    end

    assign y = taps[WIDTH-1:0];
endmodule

// File: tb/tb_mcac_delay_line.sv
// Directed bench for mcac_delay_line: a 4-channel build for the main behaviour and
// a 3-channel build for the out-of-range channel select.

module tb_mcac_delay_line;
    localparam int W = 11;
    localparam int D = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         R, en, clr;
    logic [1:0]   ch;
    logic [W-1:0] x;
    logic [D*W-1:0] taps;
    logic [W-1:0] y;
    logic         primed;

    logic         R3, en3, clr3;
    logic [1:0]   ch3;
    logic [W-1:0] x3;
    logic [D*W-1:0] taps3;
    logic [W-1:0] y3;
    logic         primed3;

    int n_cmp = 0;
    int n_err = 0;

    mcac_delay_line #(.WIDTH(W), .DEPTH(D), .NCH(4), .RESET_VALUE(32)) dut (
        .clk(clk), .R(R), .en(en), .clr(clr), .ch(ch), .x(x),
        .taps(taps), .y(y), .primed(primed)
    );

    mcac_delay_line #(.WIDTH(W), .DEPTH(D), .NCH(3), .RESET_VALUE(32)) dut3 (
        .clk(clk), .R(R3), .en(en3), .clr(clr3), .ch(ch3), .x(x3),
        .taps(taps3), .y(y3), .primed(primed3)
    );

    // Expected tap vector, tap 1 in the low bits.
    function automatic logic [D*W-1:0] tv(input int t1, t2, t3, t4, t5, t6);
        return {W'(t6), W'(t5), W'(t4), W'(t3), W'(t2), W'(t1)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b0; en = 1'b0; clr = 1'b0; ch = 2'd0; x = '0;
        R3 = 1'b0; en3 = 1'b0; clr3 = 1'b0; ch3 = 2'd0; x3 = '0;
        step(); step();
        R = 1'b1; R3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            ch = 2'(c); #1;
            n_cmp++;
            if (taps !== tv(32,32,32,32,32,32)) begin
                n_err++; $display("FAIL reset_taps ch%0d got %h exp %h", c, taps, tv(32,32,32,32,32,32));
            end
            n_cmp++;
            if (y !== 11'd32) begin n_err++; $display("FAIL reset_y ch%0d got %0d exp 32", c, y); end
            n_cmp++;
            if (primed !== 1'b0) begin n_err++; $display("FAIL reset_primed ch%0d got %b exp 0", c, primed); end
        end
    endtask

    task automatic test_fill();
        ch = 2'd1; en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            x = W'(i);
            step();
            if (i == 5) begin
                n_cmp++;
                if (primed !== 1'b0) begin n_err++; $display("FAIL fill5_primed got %b exp 0", primed); end
            end
            if (i == 6) begin
                n_cmp++;
                if (taps !== tv(6,5,4,3,2,1)) begin
                    n_err++; $display("FAIL fill6_taps got %h exp %h", taps, tv(6,5,4,3,2,1));
                end
                n_cmp++;
                if (primed !== 1'b1) begin n_err++; $display("FAIL fill6_primed got %b exp 1", primed); end
            end
            if (i == 7) begin
                n_cmp++;
                if (taps !== tv(7,6,5,4,3,2)) begin
                    n_err++; $display("FAIL fill7_taps got %h exp %h", taps, tv(7,6,5,4,3,2));
                end
                n_cmp++;
                if (y !== 11'd7) begin n_err++; $display("FAIL fill7_y got %0d exp 7", y); end
                n_cmp++;
                if (primed !== 1'b1) begin n_err++; $display("FAIL fill7_primed got %b exp 1", primed); end
            end
        end
        en = 1'b0;
        // Idle cycle: everything holds.
        step();
        n_cmp++;
        if (taps !== tv(7,6,5,4,3,2)) begin
            n_err++; $display("FAIL idle_hold got %h exp %h", taps, tv(7,6,5,4,3,2));
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 1) continue;
            ch = 2'(c); #1;
            n_cmp++;
            if (taps !== tv(32,32,32,32,32,32)) begin
                n_err++; $display("FAIL fill_other ch%0d got %h exp %h", c, taps, tv(32,32,32,32,32,32));
            end
        end
    endtask

    task automatic test_interleave();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch = 2'd0; x = 11'd100; step();
            ch = 2'd2; x = 11'd200; step();
        end
        en = 1'b0;
        ch = 2'd0; #1;
        n_cmp++;
        if (taps !== tv(100,100,100,32,32,32)) begin
            n_err++; $display("FAIL ilv_ch0 got %h exp %h", taps, tv(100,100,100,32,32,32));
        end
        n_cmp++;
        if (primed !== 1'b0) begin n_err++; $display("FAIL ilv_ch0_primed got %b exp 0", primed); end
        ch = 2'd2; #1;
        n_cmp++;
        if (taps !== tv(200,200,200,32,32,32)) begin
            n_err++; $display("FAIL ilv_ch2 got %h exp %h", taps, tv(200,200,200,32,32,32));
        end
        n_cmp++;
        if (primed !== 1'b0) begin n_err++; $display("FAIL ilv_ch2_primed got %b exp 0", primed); end
    endtask

    task automatic test_clear();
        ch = 2'd1; clr = 1'b1; en = 1'b0;
        step();
        clr = 1'b0;
        n_cmp++;
        if (taps !== tv(32,32,32,32,32,32)) begin
            n_err++; $display("FAIL clr_taps got %h exp %h", taps, tv(32,32,32,32,32,32));
        end
        n_cmp++;
        if (primed !== 1'b0) begin n_err++; $display("FAIL clr_primed got %b exp 0", primed); end
        ch = 2'd0; #1;
        n_cmp++;
        if (taps !== tv(100,100,100,32,32,32)) begin
            n_err++; $display("FAIL clr_other got %h exp %h", taps, tv(100,100,100,32,32,32));
        end
        ch = 2'd1; en = 1'b1;
        for (int i = 1; i <= 6; i++) begin x = W'(i); step(); end
        n_cmp++;
        if (primed !== 1'b1) begin n_err++; $display("FAIL refill_primed got %b exp 1", primed); end
        clr = 1'b1; x = 11'd9;
        step();
        clr = 1'b0;
        n_cmp++;
        if (taps !== tv(9,32,32,32,32,32)) begin
            n_err++; $display("FAIL clrsmp_taps got %h exp %h", taps, tv(9,32,32,32,32,32));
        end
        n_cmp++;
        if (primed !== 1'b0) begin n_err++; $display("FAIL clrsmp_primed got %b exp 0", primed); end
        // fill restarted at 1: four more samples leave it unprimed, the fifth primes it.
        for (int i = 1; i <= 5; i++) begin
            x = W'(20 + i); step();
            if (i == 4) begin
                n_cmp++;
                if (primed !== 1'b0) begin n_err++; $display("FAIL clrsmp_fill5 got %b exp 0", primed); end
            end
        end
        en = 1'b0;
        n_cmp++;
        if (primed !== 1'b1) begin n_err++; $display("FAIL clrsmp_fill6 got %b exp 1", primed); end
        n_cmp++;
        if (taps !== tv(25,24,23,22,21,9)) begin
            n_err++; $display("FAIL clrsmp_shift got %h exp %h", taps, tv(25,24,23,22,21,9));
        end
    endtask

    task automatic test_mid_reset();
        ch = 2'd3; en = 1'b1;
        for (int i = 1; i <= 6; i++) begin x = W'(10 + i); step(); end
        n_cmp++;
        if (primed !== 1'b1) begin n_err++; $display("FAIL mrst_pre_primed got %b exp 1", primed); end
        R = 1'b0; x = 11'd55;
        step();
        R = 1'b1; en = 1'b0;
        #1;
        n_cmp++;
        if (taps !== tv(32,32,32,32,32,32)) begin
            n_err++; $display("FAIL mrst_taps got %h exp %h", taps, tv(32,32,32,32,32,32));
        end
        n_cmp++;
        if (primed !== 1'b0) begin n_err++; $display("FAIL mrst_primed got %b exp 0", primed); end
        ch = 2'd1; #1;
        n_cmp++;
        if (taps !== tv(32,32,32,32,32,32)) begin
            n_err++; $display("FAIL mrst_ch1 got %h exp %h", taps, tv(32,32,32,32,32,32));
        end
    endtask

    task automatic test_out_of_range();
        en3 = 1'b1; x3 = 11'd11;
        for (int c = 0; c < 3; c++) begin ch3 = 2'(c); step(); end
        ch3 = 2'd3; x3 = 11'd77;
        step();
        clr3 = 1'b1;
        step();
        en3 = 1'b0; clr3 = 1'b0;
        #1;
        n_cmp++;
        if (y3 !== 11'd32) begin n_err++; $display("FAIL oor_y got %0d exp 32", y3); end
        n_cmp++;
        if (taps3 !== tv(32,32,32,32,32,32)) begin
            n_err++; $display("FAIL oor_taps got %h exp %h", taps3, tv(32,32,32,32,32,32));
        end
        n_cmp++;
        if (primed3 !== 1'b0) begin n_err++; $display("FAIL oor_primed got %b exp 0", primed3); end
        for (int c = 0; c < 3; c++) begin
            ch3 = 2'(c); #1;
            n_cmp++;
            if (taps3 !== tv(11,32,32,32,32,32)) begin
                n_err++; $display("FAIL oor_hold ch%0d got %h exp %h", c, taps3, tv(11,32,32,32,32,32));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_interleave();
        test_clear();
        test_mid_reset();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
